mem_stage_mt: RTL and testbench

//  Parametrised multithreaded memory-access stage: sits between EXE and WB, drives the data cache, and registers the MEM/WB pipeline boundary.

---
 rtl/mem_stage_mt.sv | 276 +++++++++++++++++++++++++++
 tb/tb_mem_stage_mt.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_mt.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage_mt
// Description : Multithreaded memory-access stage between EXE and WB. Drives
//               the data cache, replays a missing request from hold registers
//               while stalling upstream, aligns/extends loads, builds byte
//               enables and replicated data for stores, traps misaligned or
//               illegal-size accesses, registers the MEM/WB boundary and
//               counts cycles spent waiting on cache misses.
// Ports       : clk, rst (async, active high)
//               *_mem        instruction and sideband from EXE
//               flushMEM     squash the instruction currently in MEM
//               d_miss,
//               d_rd_data    data cache response
//               *_wb         registered MEM/WB boundary
//               ld_data_wb   aligned, extended load result
//               misalign_wb  misalignment / illegal-size trap
//               stall_mem    hold EXE/MEM and all upstream stages
//               d_rd, d_wr, d_addr, d_wr_data, d_be   data cache request
//               miss_cycles  saturating count of cycles in the MISS state
// Revision    : 1.0 - initial release
// ============================================================================
module mem_stage_mt #(
    parameter int XLEN  = 32,
    parameter int TRD_W = 3,
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [XLEN-1:0]     d_addr_mem,
    input  logic [31:0]         ins_mem,
    input  logic [XLEN-1:0]     pc_mem,
    input  logic [XLEN-1:0]     new_pc_mem,
    input  logic [XLEN-1:0]     new_data_mem,
    input  logic [XLEN-1:0]     exe_data_mem,
    input  logic [TRD_W-1:0]    trd_mem,
    input  logic [TRD_W-1:0]    obj_trd_mem,
    input  logic [4:0]          reg_wr_mem,
    input  logic                wr_en_mem,
    input  logic                wb_sel_mem,
    input  logic [2:0]          trd_ctrl_mem,
    input  logic [1:0]          mem_ctrl_mem,
    input  logic [1:0]          mem_size_mem,
    input  logic                mem_sext_mem,
    input  logic                flushMEM,
    input  logic                d_miss,
    input  logic [XLEN-1:0]     d_rd_data,
    output logic [31:0]         ins_wb,
    output logic [XLEN-1:0]     pc_wb,
    output logic [XLEN-1:0]     exe_data_wb,
    output logic [TRD_W-1:0]    trd_wb,
    output logic [4:0]          reg_wr_wb,
    output logic                wr_en_wb,
    output logic [2:0]          trd_ctrl_wb,
    output logic [TRD_W-1:0]    obj_trd_wb,
    output logic                wb_sel_wb,
    output logic [XLEN-1:0]     new_pc_wb,
    output logic [XLEN-1:0]     new_data_wb,
    output logic [XLEN-1:0]     ld_data_wb,
    output logic                misalign_wb,
    output logic                stall_mem,
    output logic                d_rd,
    output logic                d_wr,
    output logic [XLEN-1:0]     d_addr,
    output logic [XLEN-1:0]     d_wr_data,
    output logic [XLEN/8-1:0]   d_be,
    output logic [CNT_W-1:0]    miss_cycles
);

    localparam int NB  = XLEN / 8;
    localparam int OFF = $clog2(NB);
    localparam logic [NB:0]     c_BE_ONE = {{NB{1'b0}}, 1'b1};
    localparam logic [XLEN-1:0] c_X_ONE  = {{(XLEN-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {S_IDLE = 1'b0, S_MISS = 1'b1} state_t;

    typedef struct packed {
        logic [31:0]      ins;
        logic [XLEN-1:0]  pc;
        logic [XLEN-1:0]  new_pc;
        logic [XLEN-1:0]  new_data;
        logic [XLEN-1:0]  exe_data;
        logic [XLEN-1:0]  ld_data;
        logic [TRD_W-1:0] trd;
        logic [TRD_W-1:0] obj_trd;
        logic [4:0]       reg_wr;
        logic             wr_en;
        logic             wb_sel;
        logic [2:0]       trd_ctrl;
        logic             misalign;
    } wb_t;

    // Select the size-aligned lane, then sign/zero-extend it to XLEN.
    function automatic logic [XLEN-1:0] f_load(input logic [XLEN-1:0] data,
                                               input logic [OFF-1:0]  lane,
                                               input logic [1:0]      size,
                                               input logic            sext);
        logic [XLEN-1:0] sh, mask, top;
        int              bits;
        sh   = data >> {lane, 3'b000};
        bits = 8 << size;
        mask = (bits >= XLEN) ? '1 : ((c_X_ONE << bits) - c_X_ONE);
        top  = mask ^ (mask >> 1);   // sign-bit position of the lane
        return (sh & mask) | ((sext && ((sh & top) != '0)) ? ~mask : '0);
    endfunction

    // Replicate the low size bytes of the store data across every byte lane.
    function automatic logic [XLEN-1:0] f_wdata(input logic [XLEN-1:0] data,
                                                input logic [1:0]      size);
        logic [XLEN-1:0] r;
        int              j;
        r = '0;
        for (int i = 0; i < NB; i++) begin
            j = i & ((1 << size) - 1);
            r[i*8 +: 8] = data[j*8 +: 8];
        end
        return r;
    endfunction

    function automatic logic [NB-1:0] f_be(input logic [OFF-1:0] lane,
                                           input logic [1:0]     size);
        logic [NB:0] ones;
        ones = (c_BE_ONE << (1 << size)) - c_BE_ONE;
        return ones[NB-1:0] << lane;
    endfunction

    state_t              r_state, w_nxt;
    wb_t                 r_wb, r_hold, w_in, w_wb_nxt;
    logic [XLEN-1:0]     r_h_addr, r_h_wdata;
    logic [NB-1:0]       r_h_be;
    logic [1:0]          r_h_size;
    logic                r_h_sext, r_h_rd, r_h_wr;
    logic [CNT_W-1:0]    r_cnt;

    logic                w_is_acc, w_mis_raw, w_mis, w_acc, w_cap, w_stall, w_rd, w_wr;
    logic [XLEN-1:0]     w_addr, w_wdata, w_st_data, w_ld_idle, w_ld_hold;
    logic [NB-1:0]       w_be, w_st_be;

    assign w_is_acc = (mem_ctrl_mem == 2'b01) || (mem_ctrl_mem == 2'b10);

    always_comb begin
        w_mis_raw = 1'b0;
        case (mem_size_mem)
            2'b01:   w_mis_raw = d_addr_mem[0];
            2'b10:   w_mis_raw = (d_addr_mem[1:0] != 2'b00);
            2'b11:   w_mis_raw = (XLEN == 32) || (d_addr_mem[2:0] != 3'b000);
            default: w_mis_raw = 1'b0;
        endcase
    end

    assign w_mis     = w_is_acc & w_mis_raw;
    assign w_acc     = w_is_acc & ~flushMEM & ~w_mis;
    assign w_st_data = f_wdata(exe_data_mem, mem_size_mem);
    assign w_st_be   = f_be(d_addr_mem[OFF-1:0], mem_size_mem);
    assign w_ld_idle = f_load(d_rd_data, d_addr_mem[OFF-1:0], mem_size_mem, mem_sext_mem);
    assign w_ld_hold = f_load(d_rd_data, r_h_addr[OFF-1:0], r_h_size, r_h_sext);

    always_comb begin
        w_in          = '0;
        w_in.ins      = ins_mem;
        w_in.pc       = pc_mem;
        w_in.new_pc   = new_pc_mem;
        w_in.new_data = new_data_mem;
        w_in.exe_data = exe_data_mem;
        w_in.ld_data  = w_ld_idle;
        w_in.trd      = trd_mem;
        w_in.obj_trd  = obj_trd_mem;
        w_in.reg_wr   = reg_wr_mem;
        w_in.wr_en    = wr_en_mem & ~w_mis;   // a trapped access never writes the RF
        w_in.wb_sel   = wb_sel_mem;
        w_in.trd_ctrl = trd_ctrl_mem;
        w_in.misalign = w_mis;
    end

    always_comb begin
        w_nxt    = r_state;
        w_wb_nxt = '0;
        w_cap    = 1'b0;
        w_stall  = 1'b0;
        w_rd     = 1'b0;
        w_wr     = 1'b0;
        w_addr   = {d_addr_mem[XLEN-1:OFF], {OFF{1'b0}}};
        w_wdata  = w_st_data;
        w_be     = w_st_be;
        case (r_state)
            S_IDLE: begin
                w_rd = w_acc & mem_ctrl_mem[0];
                w_wr = w_acc & mem_ctrl_mem[1];
                if (w_acc && d_miss) begin
                    w_nxt   = S_MISS;
                    w_cap   = 1'b1;
                    w_stall = 1'b1;
                end else if (!flushMEM) begin
                    w_wb_nxt = w_in;
                end
            end
            S_MISS: begin
                w_addr  = {r_h_addr[XLEN-1:OFF], {OFF{1'b0}}};
                w_wdata = r_h_wdata;
                w_be    = r_h_be;
                if (flushMEM) begin
                    w_nxt = S_IDLE;   // abort: request dropped, WB gets a bubble
                end else begin
                    w_rd = r_h_rd;
                    w_wr = r_h_wr;
                    if (d_miss) begin
                        w_stall = 1'b1;
                    end else begin
                        // Completing cycle: upstream advances on this same edge.
                        w_nxt            = S_IDLE;
                        w_wb_nxt         = r_hold;
                        w_wb_nxt.ld_data = w_ld_hold;
                    end
                end
            end
            default: w_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_wb      <= '0;
            r_hold    <= '0;
            r_h_addr  <= '0;
            r_h_wdata <= '0;
            r_h_be    <= '0;
            r_h_size  <= '0;
            r_h_sext  <= 1'b0;
            r_h_rd    <= 1'b0;
            r_h_wr    <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_state <= w_nxt;
            r_wb    <= w_wb_nxt;
            if (w_cap) begin
                r_hold    <= w_in;
                r_h_addr  <= d_addr_mem;
                r_h_wdata <= w_st_data;
                r_h_be    <= w_st_be;
                r_h_size  <= mem_size_mem;
                r_h_sext  <= mem_sext_mem;
                r_h_rd    <= mem_ctrl_mem[0];
                r_h_wr    <= mem_ctrl_mem[1];
            end
            if ((r_state == S_MISS) && (r_cnt != '1)) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Cache-facing outputs are forced quiet while reset is asserted.
    assign d_rd      = w_rd & ~rst;
    assign d_wr      = w_wr & ~rst;
    assign stall_mem = w_stall & ~rst;
    assign d_be      = (w_wr && !rst) ? w_be : '0;
    assign d_addr    = rst ? '0 : w_addr;
    assign d_wr_data = rst ? '0 : w_wdata;

    assign ins_wb      = r_wb.ins;
    assign pc_wb       = r_wb.pc;
    assign exe_data_wb = r_wb.exe_data;
    assign trd_wb      = r_wb.trd;
    assign reg_wr_wb   = r_wb.reg_wr;
    assign wr_en_wb    = r_wb.wr_en;
    assign trd_ctrl_wb = r_wb.trd_ctrl;
    assign obj_trd_wb  = r_wb.obj_trd;
    assign wb_sel_wb   = r_wb.wb_sel;
    assign new_pc_wb   = r_wb.new_pc;
    assign new_data_wb = r_wb.new_data;
    assign ld_data_wb  = r_wb.ld_data;
    assign misalign_wb = r_wb.misalign;
    assign miss_cycles = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_mt.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_stage_mt
// Description : Scoreboard bench for mem_stage_mt (XLEN=32). Stimulus pushes
//               expected WB records; a monitor pops and compares whenever a
//               non-bubble instruction appears at the WB boundary.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage_mt;
    localparam int XLEN = 32, TRD_W = 3, CNT_W = 16;

    logic clk = 1'b0, rst = 1'b1;
    logic [XLEN-1:0] d_addr_mem, pc_mem, new_pc_mem, new_data_mem, exe_data_mem, d_rd_data;
    logic [31:0] ins_mem;
    logic [TRD_W-1:0] trd_mem, obj_trd_mem;
    logic [4:0] reg_wr_mem;
    logic wr_en_mem, wb_sel_mem, mem_sext_mem, flushMEM, d_miss;
    logic [2:0] trd_ctrl_mem;
    logic [1:0] mem_ctrl_mem, mem_size_mem;
    logic [31:0] ins_wb;
    logic [XLEN-1:0] pc_wb, exe_data_wb, new_pc_wb, new_data_wb, ld_data_wb, d_addr, d_wr_data;
    logic [TRD_W-1:0] trd_wb, obj_trd_wb;
    logic [4:0] reg_wr_wb;
    logic wr_en_wb, wb_sel_wb, misalign_wb, stall_mem, d_rd, d_wr;
    logic [2:0] trd_ctrl_wb;
    logic [XLEN/8-1:0] d_be;
    logic [CNT_W-1:0] miss_cycles;

    mem_stage_mt #(.XLEN(XLEN), .TRD_W(TRD_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .d_addr_mem(d_addr_mem), .ins_mem(ins_mem), .pc_mem(pc_mem),
        .new_pc_mem(new_pc_mem), .new_data_mem(new_data_mem), .exe_data_mem(exe_data_mem),
        .trd_mem(trd_mem), .obj_trd_mem(obj_trd_mem), .reg_wr_mem(reg_wr_mem),
        .wr_en_mem(wr_en_mem), .wb_sel_mem(wb_sel_mem), .trd_ctrl_mem(trd_ctrl_mem),
        .mem_ctrl_mem(mem_ctrl_mem), .mem_size_mem(mem_size_mem), .mem_sext_mem(mem_sext_mem),
        .flushMEM(flushMEM), .d_miss(d_miss), .d_rd_data(d_rd_data),
        .ins_wb(ins_wb), .pc_wb(pc_wb), .exe_data_wb(exe_data_wb), .trd_wb(trd_wb),
        .reg_wr_wb(reg_wr_wb), .wr_en_wb(wr_en_wb), .trd_ctrl_wb(trd_ctrl_wb),
        .obj_trd_wb(obj_trd_wb), .wb_sel_wb(wb_sel_wb), .new_pc_wb(new_pc_wb),
        .new_data_wb(new_data_wb), .ld_data_wb(ld_data_wb), .misalign_wb(misalign_wb),
        .stall_mem(stall_mem), .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr),
        .d_wr_data(d_wr_data), .d_be(d_be), .miss_cycles(miss_cycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ins;
        logic [31:0] ld;
        logic        wr_en;
        logic        mis;
        logic [31:0] exe;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    task automatic push(input logic [31:0] ins, input logic [31:0] ld, input logic wen,
                        input logic mis, input logic [31:0] exe);
        exp_t e;
        e.ins = ins; e.ld = ld; e.wr_en = wen; e.mis = mis; e.exe = exe;
        q.push_back(e);
    endtask

    // Monitor: every non-bubble WB record is compared against the scoreboard.
    always @(negedge clk) begin
        if (!rst && ins_wb != 32'h0) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL wb_unexpected: got ins %0h required none", ins_wb);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("wb_ins", ins_wb, e.ins);
                chk("wb_ld_data", ld_data_wb, e.ld);
                chk("wb_wr_en", wr_en_wb, e.wr_en);
                chk("wb_misalign", misalign_wb, e.mis);
                chk("wb_exe_data", exe_data_wb, e.exe);
            end
        end
    end

    task automatic drive(input logic [31:0] ins, input logic [1:0] ctrl, input logic [1:0] size,
                         input logic sext, input logic [31:0] addr, input logic [31:0] exe,
                         input logic [31:0] rdd, input logic wen);
        ins_mem = ins; mem_ctrl_mem = ctrl; mem_size_mem = size; mem_sext_mem = sext;
        d_addr_mem = addr; exe_data_mem = exe; d_rd_data = rdd; wr_en_mem = wen;
        wb_sel_mem = (ctrl == 2'b01);
    endtask

    task automatic idle_in();
        drive(32'h0, 2'b00, 2'b00, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
        d_miss = 1'b0;
        flushMEM = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        pc_mem = 32'h40; new_pc_mem = 32'h44; new_data_mem = 32'h0; trd_mem = 3'd2;
        obj_trd_mem = 3'd5; reg_wr_mem = 5'd7; trd_ctrl_mem = 3'd0;
        idle_in();
        step(); step();
        @(negedge clk);
        chk("rst_miss_cycles", miss_cycles, 0);
        chk("rst_ins_wb", ins_wb, 0);
        chk("rst_wr_en_wb", wr_en_wb, 0);
        chk("rst_d_rd", d_rd, 0);
        chk("rst_stall", stall_mem, 0);
        step();
        rst = 1'b0;

        // Word load, hit
        drive(32'h11, 2'b01, 2'b10, 1'b0, 32'h100, 32'h5555, 32'hDEADBEEF, 1'b1);
        push(32'h11, 32'hDEADBEEF, 1'b1, 1'b0, 32'h5555);
        @(negedge clk);
        chk("t1_d_rd", d_rd, 1); chk("t1_d_wr", d_wr, 0); chk("t1_d_be", d_be, 0);
        chk("t1_stall", stall_mem, 0); chk("t1_d_addr", d_addr, 32'h100);
        step();

        // Byte load lane 3, signed then unsigned; half load lane 2 signed
        drive(32'h12, 2'b01, 2'b00, 1'b1, 32'h103, 32'h0, 32'h80123456, 1'b1);
        push(32'h12, 32'hFFFF_FF80, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        chk("t2_d_addr", d_addr, 32'h100);
        step();
        drive(32'h13, 2'b01, 2'b00, 1'b0, 32'h103, 32'h0, 32'h80123456, 1'b1);
        push(32'h13, 32'h0000_0080, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        chk("t2_stall", stall_mem, 0);
        step();
        drive(32'h14, 2'b01, 2'b01, 1'b1, 32'h102, 32'h0, 32'h80015678, 1'b1);
        push(32'h14, 32'hFFFF_8001, 1'b1, 1'b0, 32'h0);
        step();

        // Half store lane 2, byte store lane 1
        drive(32'h15, 2'b10, 2'b01, 1'b0, 32'h102, 32'h1234ABCD, 32'h0, 1'b0);
        push(32'h15, 32'h0, 1'b0, 1'b0, 32'h1234ABCD);
        @(negedge clk);
        chk("t3_d_wr", d_wr, 1); chk("t3_d_rd", d_rd, 0);
        chk("t3_wdata", d_wr_data, 32'hABCDABCD); chk("t3_be", d_be, 4'b1100);
        step();
        drive(32'h16, 2'b10, 2'b00, 1'b0, 32'h101, 32'hAABBCC77, 32'h0, 1'b0);
        push(32'h16, 32'h0, 1'b0, 1'b0, 32'hAABBCC77);
        @(negedge clk);
        chk("t3b_wdata", d_wr_data, 32'h77777777); chk("t3b_be", d_be, 4'b0010);
        step();
        idle_in();
        @(negedge clk);
        chk("idle_be", d_be, 0);
        step();

        // Miss: d_miss high in the issue cycle plus three MISS cycles
        drive(32'h21, 2'b01, 2'b10, 1'b0, 32'h200, 32'h99, 32'h0, 1'b1);
        d_miss = 1'b1;
        @(negedge clk);
        chk("t4_stall_issue", stall_mem, 1); chk("t4_rd_issue", d_rd, 1);
        step();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t4_stall", stall_mem, 1); chk("t4_rd", d_rd, 1);
            chk("t4_addr", d_addr, 32'h200); chk("t4_bubble", wr_en_wb, 0);
            step();
        end
        d_miss = 1'b0;
        d_rd_data = 32'hCAFEF00D;
        push(32'h21, 32'hCAFEF00D, 1'b1, 1'b0, 32'h99);
        @(negedge clk);
        chk("t4_stall_done", stall_mem, 0); chk("t4_rd_done", d_rd, 1);
        step();
        idle_in();
        @(negedge clk);
        chk("t4_miss_cycles", miss_cycles, 4);
        step();

        // Flush in the second MISS cycle
        drive(32'h31, 2'b01, 2'b10, 1'b0, 32'h300, 32'h0, 32'h0, 1'b1);
        d_miss = 1'b1;
        step();
        @(negedge clk);
        chk("t5_stall_m1", stall_mem, 1);
        step();
        flushMEM = 1'b1;
        @(negedge clk);
        chk("t5_rd_flush", d_rd, 0);
        step();
        idle_in();
        @(negedge clk);
        chk("t5_stall_after", stall_mem, 0); chk("t5_wr_en_wb", wr_en_wb, 0);
        chk("t5_miss_cycles", miss_cycles, 6); chk("t5_rd_after", d_rd, 0);
        step();

        // Misaligned word load, illegal dword, misaligned word store
        drive(32'h41, 2'b01, 2'b10, 1'b0, 32'h102, 32'h7, 32'h0, 1'b1);
        push(32'h41, 32'h0, 1'b0, 1'b1, 32'h7);
        @(negedge clk);
        chk("t6_rd", d_rd, 0); chk("t6_stall", stall_mem, 0);
        step();
        drive(32'h42, 2'b01, 2'b11, 1'b0, 32'h100, 32'h8, 32'h0, 1'b1);
        push(32'h42, 32'h0, 1'b0, 1'b1, 32'h8);
        @(negedge clk);
        chk("t6_dword_rd", d_rd, 0);
        step();
        drive(32'h43, 2'b10, 2'b10, 1'b0, 32'h101, 32'h5, 32'h0, 1'b0);
        push(32'h43, 32'h0, 1'b0, 1'b1, 32'h5);
        @(negedge clk);
        chk("t6_st_wr", d_wr, 0); chk("t6_st_be", d_be, 0);
        step();

        // Flush in IDLE: no strobe, bubble
        drive(32'h44, 2'b01, 2'b10, 1'b0, 32'h100, 32'h0, 32'h1, 1'b1);
        flushMEM = 1'b1;
        @(negedge clk);
        chk("flush_idle_rd", d_rd, 0);
        step();
        idle_in();

        // Reset asserted in the middle of a MISS cycle
        drive(32'h51, 2'b01, 2'b10, 1'b0, 32'h400, 32'h0, 32'h0, 1'b1);
        d_miss = 1'b1;
        step();
        #2;
        rst = 1'b1;
        #1;
        chk("rst_mid_rd", d_rd, 0); chk("rst_mid_stall", stall_mem, 0);
        chk("rst_mid_cnt", miss_cycles, 0); chk("rst_mid_ins_wb", ins_wb, 0);
        chk("rst_mid_addr", d_addr, 0);
        idle_in();
        step();
        rst = 1'b0;

        drive(32'h61, 2'b01, 2'b10, 1'b0, 32'h500, 32'h3, 32'h13579BDF, 1'b1);
        push(32'h61, 32'h13579BDF, 1'b1, 1'b0, 32'h3);
        @(negedge clk);
        chk("post_rst_stall", stall_mem, 0); chk("post_rst_rd", d_rd, 1);
        step();
        idle_in();
        step(); step();
        chk("queue_empty", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
